// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and types for the IF-stage fetch PC controller.
// Holds the reset fetch address, the instruction stride and FSM state type.
package pc_fetch_ctrl_pkg;

    localparam int unsigned ADDR_BUS_W   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] INST_STRIDE  = 32'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle between pipeline controller / ID / imem and IF.
// master: drives stall/flush/exc_pc/branch_*/inst_ready; slave: drives pc,
// rom_en, fetch_stall_req, fetch_addr_err and redirect_pending.
interface pc_fetch_ctrl_if #(
    parameter int AW = 32
);
    logic          stall;
    logic          flush;
    logic [AW-1:0] exc_pc;
    logic          branch_flag;
    logic [AW-1:0] branch_addr;
    logic          inst_ready;
    logic [AW-1:0] pc;
    logic          rom_en;
    logic          fetch_stall_req;
    logic          fetch_addr_err;
    logic          redirect_pending;

    modport master (
        output stall, flush, exc_pc, branch_flag, branch_addr, inst_ready,
        input  pc, rom_en, fetch_stall_req, fetch_addr_err, redirect_pending
    );

    modport slave (
        input  stall, flush, exc_pc, branch_flag, branch_addr, inst_ready,
        output pc, rom_en, fetch_stall_req, fetch_addr_err, redirect_pending
    );
endinterface

// File: rtl/pc_fetch_ctrl_redirect_latch.sv
// pc_redirect_latch: single-entry buffer for a branch target seen during stall.
// Ports: clk, rst, set_i/addr_i load, clr_i empties, valid_o/addr_o current entry.
module pc_redirect_latch #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o
);
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;

    // Clear wins so a flush always empties the buffer.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch PC and instruction-memory request controller.
// Ports: clk, rst (async high), bus (slave side of pc_fetch_ctrl_if).
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                   ADDR_WIDTH = ADDR_BUS_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = RESET_PC_DEF[ADDR_WIDTH-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    pc_fetch_ctrl_if.slave bus
);
    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  rom_en;
    logic                  pend_set, pend_clr, pend_valid;
    logic [ADDR_WIDTH-1:0] pend_addr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // BOOT lasts one cycle; RUN holds until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Outputs of the FSM.
    always_comb begin
        rom_en = (state_q == RUN);
    end

    // Next-PC selection; flush beats everything, even in BOOT.
    always_comb begin
        pc_d     = pc_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (bus.flush) begin
            pc_d     = bus.exc_pc;
            pend_clr = 1'b1;
        end else if (state_q == RUN) begin
            if (bus.stall) begin
                pend_set = bus.branch_flag;
            end else if (pend_valid) begin
                // A buffered target wins over a same-cycle branch.
                pc_d     = pend_addr;
                pend_clr = 1'b1;
            end else if (bus.branch_flag) begin
                pc_d = bus.branch_addr;
            end else begin
                pc_d = pc_q + ADDR_WIDTH'(INST_STRIDE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    pc_redirect_latch #(
        .AW(ADDR_WIDTH)
    ) u_redirect (
        .clk    (clk),
        .rst    (rst),
        .set_i  (pend_set),
        .clr_i  (pend_clr),
        .addr_i (bus.branch_addr),
        .valid_o(pend_valid),
        .addr_o (pend_addr)
    );

    assign bus.pc               = pc_q;
    assign bus.rom_en           = rom_en;
    assign bus.fetch_stall_req  = rom_en & ~bus.inst_ready;
    assign bus.fetch_addr_err   = rom_en & (|pc_q[1:0]);
    assign bus.redirect_pending = pend_valid;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scoreboard bench for pc_fetch_ctrl.
// Expected output sets are queued at drive time and checked after each edge.
module tb_pc_fetch_ctrl;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        rom;
        logic        fsr;
        logic        err;
        logic        pend;
    } exp_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    exp_t sb[$];

    pc_fetch_ctrl_if #(.AW(32)) bus ();

    pc_fetch_ctrl #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'hBFC0_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A buffered target meeting a new unstalled branch is illegal upstream.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.redirect_pending && !bus.stall &&
                      bus.branch_flag && !bus.flush))
            else begin
                nerr++;
                $error("FAIL pend_vs_branch observed=1 expected=0");
            end
        end
    end

    task automatic drive(input logic st, input logic fl,
                         input logic [31:0] epc, input logic bf,
                         input logic [31:0] ba, input logic ir);
        bus.stall       = st;
        bus.flush       = fl;
        bus.exc_pc      = epc;
        bus.branch_flag = bf;
        bus.branch_addr = ba;
        bus.inst_ready  = ir;
    endtask

    task automatic chk(input string tag, input logic [31:0] pc,
                       input logic rom, input logic fsr, input logic err,
                       input logic pend, input bit clocked);
        exp_t e;
        sb.push_back('{tag, pc, rom, fsr, err, pend});
        if (clocked) begin
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        nvec++;
        assert (bus.pc === e.pc) else begin
            nerr++;
            $error("FAIL %s pc observed=%h expected=%h", e.tag, bus.pc, e.pc);
        end
        nvec++;
        assert (bus.rom_en === e.rom) else begin
            nerr++;
            $error("FAIL %s rom_en observed=%b expected=%b",
                   e.tag, bus.rom_en, e.rom);
        end
        nvec++;
        assert (bus.fetch_stall_req === e.fsr) else begin
            nerr++;
            $error("FAIL %s fetch_stall_req observed=%b expected=%b",
                   e.tag, bus.fetch_stall_req, e.fsr);
        end
        nvec++;
        assert (bus.fetch_addr_err === e.err) else begin
            nerr++;
            $error("FAIL %s fetch_addr_err observed=%b expected=%b",
                   e.tag, bus.fetch_addr_err, e.err);
        end
        nvec++;
        assert (bus.redirect_pending === e.pend) else begin
            nerr++;
            $error("FAIL %s redirect_pending observed=%b expected=%b",
                   e.tag, bus.redirect_pending, e.pend);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        #3;
        chk("reset", 32'hBFC0_0000, 0, 0, 0, 0, 0);

        // Release: one BOOT cycle, then sequential fetch.
        @(negedge clk); rst = 1'b0;
        chk("boot", 32'hBFC0_0000, 1, 0, 0, 0, 1);
        @(negedge clk); chk("seq4", 32'hBFC0_0004, 1, 0, 0, 0, 1);
        @(negedge clk); chk("seq8", 32'hBFC0_0008, 1, 0, 0, 0, 1);
        @(negedge clk); chk("seqc", 32'hBFC0_000C, 1, 0, 0, 0, 1);
        @(negedge clk); chk("seq10", 32'hBFC0_0010, 1, 0, 0, 0, 1);

        // Taken branch.
        @(negedge clk); drive(0, 0, 32'h0, 1, 32'hBFC0_0100, 1);
        chk("br_taken", 32'hBFC0_0100, 1, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("br_next", 32'hBFC0_0104, 1, 0, 0, 0, 1);

        // Branch arrives during a 3-cycle stall.
        @(negedge clk); drive(1, 0, 32'h0, 1, 32'hBFC0_0200, 1);
        chk("stl1", 32'hBFC0_0104, 1, 0, 0, 1, 1);
        @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("stl2", 32'hBFC0_0104, 1, 0, 0, 1, 1);
        @(negedge clk); chk("stl3", 32'hBFC0_0104, 1, 0, 0, 1, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("stl_rel", 32'hBFC0_0200, 1, 0, 0, 0, 1);
        @(negedge clk); chk("after_rel", 32'hBFC0_0204, 1, 0, 0, 0, 1);

        // Flush beats stall, branch and a pending entry.
        @(negedge clk); drive(1, 0, 32'h0, 1, 32'hBFC0_0300, 1);
        chk("pre_flush", 32'hBFC0_0204, 1, 0, 0, 1, 1);
        @(negedge clk); drive(1, 1, 32'hBFC0_0380, 1, 32'hBFC0_0300, 1);
        chk("flush", 32'hBFC0_0380, 1, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("post_flush", 32'hBFC0_0384, 1, 0, 0, 0, 1);

        // Memory wait with controller stall feedback.
        @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 0);
        chk("memwait1", 32'hBFC0_0384, 1, 1, 0, 0, 1);
        @(negedge clk); chk("memwait2", 32'hBFC0_0384, 1, 1, 0, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("memdone", 32'hBFC0_0388, 1, 0, 0, 0, 1);

        // Misaligned target keeps sequencing.
        @(negedge clk); drive(0, 0, 32'h0, 1, 32'hBFC0_0102, 1);
        chk("misalign", 32'hBFC0_0102, 1, 0, 1, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("mis_seq", 32'hBFC0_0106, 1, 0, 1, 0, 1);

        // Recovery by flush, then wrap of pc + 4.
        @(negedge clk); drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
        chk("wrap_pre", 32'hFFFF_FFFC, 1, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("wrap", 32'h0000_0000, 1, 0, 0, 0, 1);

        // Asynchronous reset while a redirect is pending.
        @(negedge clk); drive(1, 0, 32'h0, 1, 32'hBFC0_0500, 1);
        chk("rst_pre", 32'h0000_0000, 1, 0, 0, 1, 1);
        @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid", 32'hBFC0_0000, 0, 0, 0, 0, 0);
        chk("rst_hold", 32'hBFC0_0000, 0, 0, 0, 0, 1);

        // Flush during BOOT loads exc_pc; branch and stall are ignored.
        @(negedge clk); rst = 1'b0;
        drive(1, 1, 32'hBFC0_0040, 1, 32'hBFC0_0600, 1);
        chk("boot_flush", 32'hBFC0_0040, 1, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("boot_next", 32'hBFC0_0044, 1, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
